// File: rtl/cgra_pkg.sv
// Shared constants, header/word encodings and sequencer state type for the
// four-tile compute array controller.
package cgra_pkg;

  localparam int NUM_TILES = 4;

  localparam logic [1:0] HDR_WEIGHT = 2'b00;
  localparam logic [1:0] HDR_LINK   = 2'b01;
  localparam logic [1:0] HDR_RUN    = 2'b10;
  localparam logic [1:0] HDR_RSVD   = 2'b11;

  localparam logic [1:0] PFX_WEIGHT = 2'b00;
  localparam logic [1:0] PFX_LINK   = 2'b01;
  localparam logic [1:0] PFX_DATA   = 2'b10;

  localparam logic [7:0] NOP_WORD_DFLT = 8'h80;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CFG,
    S_GET_OPND,
    S_DRIVE,
    S_CAPTURE,
    S_EMIT
  } state_t;

  // Builds a full switch bus with word w on lane idx and nop on every other lane.
  function automatic logic [31:0] place_lane(input logic [1:0] idx,
                                             input logic [7:0] w,
                                             input logic [7:0] nop);
    logic [31:0] r;
    for (int k = 0; k < NUM_TILES; k++) begin
      r[k*8 +: 8] = (idx == 2'(k)) ? w : nop;
    end
    return r;
  endfunction

endpackage

// File: rtl/cgra_route_table.sv
// Shadow copy of each tile's link target and op, used to walk run chains.
module cgra_route_table
  import cgra_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       we,
  input  logic [1:0] wr_tile,
  input  logic [1:0] wr_next,
  input  logic       wr_op,
  input  logic [1:0] rd_tile,
  output logic [1:0] rd_next,
  output logic       rd_op
);

  logic [1:0] next_q [NUM_TILES];
  logic       op_q   [NUM_TILES];

  // Reset state is the ring 0->1->2->3->0 with every tile adding.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_TILES; i++) begin
        next_q[i] <= 2'((i + 1) % NUM_TILES);
        op_q[i]   <= 1'b0;
      end
    end else if (we) begin
      next_q[wr_tile] <= wr_next;
      op_q[wr_tile]   <= wr_op;
    end
  end

  assign rd_next = next_q[rd_tile];
  assign rd_op   = op_q[rd_tile];

endmodule

// File: rtl/cgra_tile_sequencer.sv
// Host-command sequencer: decodes header bytes into tile switch words, walks
// operand chains through the tiles and returns the last tile's output.
module cgra_tile_sequencer
  import cgra_pkg::*;
#(
  parameter logic [7:0] NOP_WORD = NOP_WORD_DFLT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  host_data,
  input  logic        host_valid,
  output logic        host_ready,
  output logic [31:0] tile_dout,
  input  logic [31:0] tile_din,
  output logic [7:0]  res_data,
  output logic        res_valid,
  input  logic        res_ready,
  output logic        busy,
  output logic        err
);

  // Both handshakes transfer on a rising edge where valid && ready are high;
  // a producer facing ready low must hold its data stable until that edge.

  state_t     state;
  logic [1:0] cur;
  logic [1:0] remaining;
  logic [1:0] rt_next;
  logic       op_unused;
  logic [7:0] cur_din;
  logic       link_we;

  assign host_ready = rst_n && (state == S_IDLE || state == S_GET_OPND);
  assign busy       = (state != S_IDLE);
  assign cur_din    = tile_din[{cur, 3'b000} +: 8];
  assign link_we    = (state == S_IDLE) && host_valid && (host_data[7:6] == HDR_LINK);

  cgra_route_table u_route (
    .clk     (clk),
    .rst_n   (rst_n),
    .we      (link_we),
    .wr_tile (host_data[5:4]),
    .wr_next (host_data[3:2]),
    .wr_op   (host_data[0]),
    .rd_tile (cur),
    .rd_next (rt_next),
    .rd_op   (op_unused)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      tile_dout <= {NUM_TILES{NOP_WORD}};
      cur       <= 2'd0;
      remaining <= 2'd0;
      res_data  <= 8'd0;
      res_valid <= 1'b0;
      err       <= 1'b0;
    end else begin
      err <= 1'b0;
      case (state)
        S_IDLE: begin
          if (host_valid) begin
            case (host_data[7:6])
              HDR_WEIGHT: begin
                tile_dout <= place_lane(host_data[5:4], {PFX_WEIGHT, 2'b00, host_data[3:0]}, NOP_WORD);
                state     <= S_CFG;
              end
              HDR_LINK: begin
                tile_dout <= place_lane(host_data[5:4],
                                        {PFX_LINK, host_data[3:2], 3'b000, host_data[0]}, NOP_WORD);
                state     <= S_CFG;
              end
              HDR_RUN: begin
                cur       <= host_data[5:4];
                remaining <= host_data[1:0];
                state     <= S_GET_OPND;
              end
              default: err <= 1'b1;
            endcase
          end
        end
        S_CFG: begin
          tile_dout <= {NUM_TILES{NOP_WORD}};
          state     <= S_IDLE;
        end
        S_GET_OPND: begin
          if (host_valid) begin
            tile_dout <= place_lane(cur, {PFX_DATA, 2'b00, host_data[3:0]}, NOP_WORD);
            state     <= S_DRIVE;
          end
        end
        S_DRIVE: begin
          tile_dout <= {NUM_TILES{NOP_WORD}};
          state     <= S_CAPTURE;
        end
        S_CAPTURE: begin
          // Only the low nibble of an intermediate result travels to the next tile.
          if (remaining != 2'd0) begin
            cur       <= rt_next;
            remaining <= remaining - 2'd1;
            tile_dout <= place_lane(rt_next, {PFX_DATA, 2'b00, cur_din[3:0]}, NOP_WORD);
            state     <= S_DRIVE;
          end else begin
            res_data  <= cur_din;
            res_valid <= 1'b1;
            state     <= S_EMIT;
          end
        end
        S_EMIT: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cgra_tile_sequencer.sv
// Directed plus randomized bench for cgra_tile_sequencer with four behavioural
// compute tiles attached to the switch ports.
module tb_cgra_tile_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  host_data;
  logic        host_valid;
  logic        host_ready;
  logic [31:0] tile_dout;
  logic [31:0] tile_din;
  logic [7:0]  res_data;
  logic        res_valid;
  logic        res_ready;
  logic        busy;
  logic        err;

  int checks   = 0;
  int failures = 0;

  logic [7:0] exp_q[$];
  logic [3:0] mw   [4];
  logic       mop  [4];
  logic [1:0] mnext[4];
  logic [7:0] obs_res;

  always #5 clk = ~clk;

  cgra_tile_sequencer dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .host_data  (host_data),
    .host_valid (host_valid),
    .host_ready (host_ready),
    .tile_dout  (tile_dout),
    .tile_din   (tile_din),
    .res_data   (res_data),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .busy       (busy),
    .err        (err)
  );

  // Behavioural tiles: weight/link words configure, data words register a result.
  logic [7:0] t_out[4];
  logic [3:0] t_w  [4];
  logic       t_op [4];

  always @(posedge clk) begin
    for (int k = 0; k < 4; k++) begin
      if (!rst_n) begin
        t_out[k] <= 8'd0;
        t_w[k]   <= 4'd0;
        t_op[k]  <= 1'b0;
      end else begin
        case (tile_dout[k*8+6 +: 2])
          2'b00:   t_w[k]  <= tile_dout[k*8 +: 4];
          2'b01:   t_op[k] <= tile_dout[k*8];
          2'b10:   t_out[k] <= t_op[k] ? (tile_dout[k*8 +: 8] - {4'h0, t_w[k]})
                                       : ({4'h0, tile_dout[k*8 +: 4]} + {4'h0, t_w[k]});
          default: t_out[k] <= t_out[k];
        endcase
      end
    end
  end

  assign tile_din = {t_out[3], t_out[2], t_out[1], t_out[0]};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      mw[i]    = 4'd0;
      mop[i]   = 1'b0;
      mnext[i] = 2'((i + 1) % 4);
    end
  endtask

  function automatic logic [31:0] lanes(input int t, input logic [7:0] w);
    logic [31:0] r;
    r = 32'h80808080;
    r[t*8 +: 8] = w;
    return r;
  endfunction

  // Called at a falling edge; returns at the falling edge after the accepting edge.
  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    host_data  = b;
    host_valid = 1'b1;
    while (!host_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("ready_timeout", host_ready, 1);
    @(negedge clk);
    host_valid = 1'b0;
    host_data  = $urandom_range(0, 255);
  endtask

  task automatic do_weight(input logic [1:0] t, input logic [3:0] w);
    send_byte({2'b00, t, w});
    mw[t] = w;
    chk("weight_lane", tile_dout, lanes(t, {4'h0, w}));
    chk("cfg_ready_low", host_ready, 0);
    @(negedge clk);
    chk("weight_nop", tile_dout, 32'h80808080);
    chk("cfg_ready_back", host_ready, 1);
  endtask

  task automatic do_link(input logic [1:0] t, input logic [1:0] n, input logic op, input logic junk);
    send_byte({2'b01, t, n, junk, op});
    mnext[t] = n;
    mop[t]   = op;
    chk("link_lane", tile_dout, lanes(t, {2'b01, n, 3'b000, op}));
    @(negedge clk);
    chk("link_nop", tile_dout, 32'h80808080);
  endtask

  task automatic do_run(input logic [1:0] s, input logic [1:0] h, input logic [7:0] opnd,
                        input int stall);
    logic [3:0] v;
    int         t;
    logic [7:0] r;
    v = opnd[3:0];
    t = s;
    r = 8'd0;
    send_byte({2'b10, s, 2'($urandom_range(0, 3)), h});
    chk("run_busy", busy, 1);
    send_byte(opnd);
    for (int j = 0; j <= h; j++) begin
      chk("hop_lane", tile_dout, lanes(t, {4'h8, v}));
      r = mop[t] ? ({4'h8, v} - {4'h0, mw[t]}) : ({4'h0, v} + {4'h0, mw[t]});
      @(negedge clk);
      chk("drive_nop", tile_dout, 32'h80808080);
      chk("early_valid", res_valid, 0);
      @(negedge clk);
      if (j < h) begin
        v = r[3:0];
        t = mnext[t];
      end
    end
    exp_q.push_back(r);
    chk("res_valid", res_valid, 1);
    obs_res = res_data;
    chk("res_data", res_data, exp_q.pop_front());
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      chk("stall_data", res_data, r);
      chk("stall_valid", res_valid, 1);
      chk("stall_ready", host_ready, 0);
    end
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    chk("post_valid", res_valid, 0);
    chk("post_ready", host_ready, 1);
    chk("post_busy", busy, 0);
  endtask

  initial begin
    rst_n      = 1'b0;
    host_data  = 8'd0;
    host_valid = 1'b0;
    res_ready  = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    chk("rst_lanes", tile_dout, 32'h80808080);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_res_data", res_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", err, 0);
    chk("rst_ready", host_ready, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rel_ready", host_ready, 1);

    do_weight(2'd2, 4'd5);
    do_weight(2'd0, 4'd3);
    do_run(2'd0, 2'd0, 8'h04, 0);
    chk("spec_single", obs_res, 8'h07);

    do_weight(2'd0, 4'd1);
    do_weight(2'd1, 4'd2);
    do_weight(2'd2, 4'd3);
    do_run(2'd0, 2'd2, 8'h05, 1);
    chk("spec_chain", obs_res, 8'h0B);

    do_weight(2'd1, 4'd2);
    do_link(2'd1, 2'd3, 1'b1, 1'b0);
    do_run(2'd1, 2'd0, 8'h05, 0);
    chk("spec_sub", obs_res, 8'h83);
    do_run(2'd1, 2'd1, 8'h05, 2);

    do_run(2'd0, 2'd3, 8'hA7, 10);

    send_byte(8'hC0);
    chk("err_pulse", err, 1);
    chk("err_idle", busy, 0);
    @(negedge clk);
    chk("err_clear", err, 0);

    for (int it = 0; it < 40; it++) begin
      case ($urandom_range(0, 2))
        0: do_weight(2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)));
        1: do_link(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                   1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        default: do_run(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                        8'($urandom_range(0, 255)), $urandom_range(0, 3));
      endcase
    end

    // Abort a run while it is capturing the first hop.
    send_byte(8'h81);
    send_byte(8'h09);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("abort_lanes", tile_dout, 32'h80808080);
    chk("abort_valid", res_valid, 0);
    chk("abort_busy", busy, 0);
    chk("abort_ready", host_ready, 0);
    model_reset();
    rst_n = 1'b1;
    @(negedge clk);
    do_weight(2'd0, 4'd6);
    do_run(2'd3, 2'd1, 8'h02, 0);
    chk("ring_after_rst", obs_res, 8'h08);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cgra_tile_sequencer.md
# cgra_tile_sequencer

Central controller for the four-tile mini-AIE compute array. It accepts a byte-wide host command stream and turns it into per-tile switch words: weight loads, link/op configuration, and operand data. It runs operands through a chain of tiles by following a shadow routing table, and returns the final tile output on a result handshake. It sits between the host byte interface and the four compute-tile switch ports, and is the only driver of those ports.

## Interface
- Parameters:
  - NOP_WORD, 8'h80 — idle word driven on every lane. It is a data-class word, so it never disturbs tile weight or configuration.
- Ports:
  - clk  in  1  system clock
  - rst_n  in  1  reset; synchronous, active-low
  - host_data  in  8  command/operand byte
  - host_valid  in  1  host byte valid
  - host_ready  out  1  sequencer accepts a byte (combinational from state; 0 while rst_n low)
  - tile_dout  out  32  switch word to tile k on bits [8k+7:8k]; registered
  - tile_din  in  32  switch output of tile k on bits [8k+7:8k]
  - res_data  out  8  result byte; registered
  - res_valid  out  1  result valid
  - res_ready  in  1  result consumer ready
  - busy  out  1  state is not IDLE
  - err  out  1  one-cycle pulse when a reserved header is received

## Operation
- Header formats, decoded on host_data[7:6]:
  - 00 WEIGHT: [5:4] tile, [3:0] weight. Lane word is {4'b0000, w}.
  - 01 LINK: [5:4] tile, [3:2] next, [0] op. Lane word is {2'b01, next, 3'b000, op}. Also updates the shadow next[tile] and op[tile] entries.
  - 10 RUN: [5:4] start tile, [1:0] hops. The run visits hops+1 tiles. The next accepted byte is the operand; only bits [3:0] are used.
  - 11: reserved. The byte is consumed, err pulses, state stays IDLE.
- States:
  - IDLE: host_ready=1. WEIGHT or LINK goes to CFG; RUN goes to GET_OPND.
  - CFG: one cycle, host_ready=0, then IDLE.
  - GET_OPND: host_ready=1. On handshake, load {4'b1000, opnd[3:0]} into lane cur=start and go to DRIVE.
  - DRIVE: one cycle; lane cur returns to NOP_WORD; go to CAPTURE.
  - CAPTURE: sample tile_din lane cur.
    - Remaining hops > 0: cur ← next[cur], decrement remaining, load {4'b1000, tile_din[cur_old][3:0]} into the new lane, go to DRIVE.
    - Otherwise: res_data ← full 8-bit tile_din lane cur, res_valid=1, go to EMIT.
  - EMIT: hold res_data and res_valid until res_ready; then res_valid=0 and go to IDLE.
- Lanes not being written always carry NOP_WORD. At most one lane carries a non-NOP word in any cycle.
- The chain may revisit a tile (for example, when next[x]=x); each hop is strictly sequential.
- The result is the tile's output byte passed through unmodified. Reference model, which the verifier relies on:
  - add: v + w, zero-extended.
  - sub: ({4'b1000, v} − w) mod 256.
- Reset values:
  - tile_dout = {4{NOP_WORD}}
  - res_data = 0, res_valid = 0, err = 0
  - state IDLE
  - next[i] = (i+1) mod 4, op[i] = 0
- Reset mid-operation: any in-flight run or result is dropped. Lanes go to NOP on the first edge with rst_n low.

## Timing
- WEIGHT/LINK header accepted at edge E:
  - lane word is valid during cycle E..E+1;
  - NOP from edge E+1;
  - next header can be accepted at edge E+2.
- RUN operand accepted at edge E:
  - hop j word is loaded at edge E+2j;
  - the tile registers its output at E+2j+1;
  - the sequencer samples it at E+2j+2.
- res_valid rises at edge E+2(hops+1); res_data is stable while res_valid=1 and res_ready=0.
- Result handshake at edge F: host_ready=1 from F, so the next header can be accepted at edge F+1.
- host_valid with host_ready=0: the byte is not consumed and the host must hold it.

## Structure
- Shared package cgra_pkg holds:
  - header opcode constants HDR_WEIGHT=2'b00, HDR_LINK=2'b01, HDR_RUN=2'b10, HDR_RSVD=2'b11;
  - tile word prefixes (weight 2'b00, link 2'b01, data 2'b10);
  - NOP_WORD default;
  - the state enum;
  - the NUM_TILES=4 constant.
- Sub-module cgra_route_table holds the shadow next[4]/op[4] table:
  - one write port from LINK;
  - one combinational read port indexed by cur;
  - reset to the default ring.
- The FSM, lane mux and result register live in the top module.

## Test plan
- Reset: hold rst_n low 2 cycles → tile_dout=32'h80808080, res_valid=0, busy=0, host_ready=0; after release host_ready=1.
- WEIGHT 0x25 → lane 2 = 0x05 for exactly one cycle then 0x80; lanes 0, 1, 3 stay 0x80; host_ready low for one cycle.
- Single hop with real tiles: WEIGHT 0x03, RUN 0x80, operand 0x04 → lane 0 = 0x84; res_data=0x07 with res_valid at operand edge +2.
- Three-hop chain, default links: weights t0=1, t1=2, t2=3; RUN 0x82, operand 0x05 → lanes 0x85, 0x86, 0x88 in order; res_data=0x0B at operand edge +6.
- Subtract with relink:
  - WEIGHT 0x12 and LINK 0x5D → lane 1 = 0x71.
  - RUN 0x90, operand 0x05 → res_data=0x83.
  - RUN 0x91, operand 0x05 visits tile 1 then tile 3.
- Backpressure and abort:
  - Hold res_ready low 10 cycles → res_data stable and host_ready=0.
  - Header 0xC0 → err pulses for 1 cycle.
  - rst_n low during CAPTURE → next cycle lanes all 0x80, res_valid=0, state IDLE.
